// File: rtl/usb_rx_timer.sv
// USB receive bit timer: realigns a per-bit phase counter on every D+ edge and
// produces a mid-bit shift strobe plus a byte-complete strobe every BITS_PER_BYTE bits.
module usb_rx_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             d_edge,
  input  logic                             rcving,
  output logic                             shift_enable,
  output logic                             byte_received,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_count
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_PER_BYTE);

  localparam logic [PW-1:0] PHASE_ZERO   = '0;
  localparam logic [PW-1:0] PHASE_ONE    = PW'(1);
  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [BW-1:0] BIT_ZERO     = '0;
  localparam logic [BW-1:0] BIT_ONE      = BW'(1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_BYTE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;

  // Decoded purely from registered state, so a resync edge arriving on the
  // sample cycle cannot cancel the strobe already in progress.
  assign shift_enable = (state == RUN) && (phase == PHASE_SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= PHASE_ZERO;
      bit_count     <= BIT_ZERO;
      byte_received <= 1'b0;
    end else begin
      // Dropping the receive window discards the byte, so its strobe is gated too.
      byte_received <= shift_enable && (bit_count == BIT_LAST) && rcving;

      case (state)
        IDLE: begin
          phase     <= PHASE_ZERO;
          bit_count <= BIT_ZERO;
          if (rcving && d_edge) begin
            // The edge cycle itself counts as phase 0.
            state <= RUN;
            phase <= PHASE_ONE;
          end
        end

        RUN: begin
          if (!rcving) begin
            state     <= IDLE;
            phase     <= PHASE_ZERO;
            bit_count <= BIT_ZERO;
          end else begin
            if (d_edge) begin
              phase <= PHASE_ONE;
            end else if (phase == PHASE_LAST) begin
              phase <= PHASE_ZERO;
            end else begin
              phase <= phase + PHASE_ONE;
            end

            if (shift_enable) begin
              if (bit_count == BIT_LAST) begin
                bit_count <= BIT_ZERO;
              end else begin
                bit_count <= bit_count + BIT_ONE;
              end
            end
          end
        end

        default: begin
          state     <= IDLE;
          phase     <= PHASE_ZERO;
          bit_count <= BIT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer: default timing instance plus a fast
// CLKS_PER_BIT=4 / SAMPLE_POINT=1 instance sharing the same stimulus.
module tb_usb_rx_timer;

  logic       clk;
  logic       rst;
  logic       d_edge;
  logic       rcving;

  logic       se8;
  logic       br8;
  logic [2:0] bc8;
  logic       se4;
  logic       br4;
  logic [2:0] bc4;

  int checks = 0;
  int errors = 0;

  usb_rx_timer dut8 (
    .clk           (clk),
    .rst           (rst),
    .d_edge        (d_edge),
    .rcving        (rcving),
    .shift_enable  (se8),
    .byte_received (br8),
    .bit_count     (bc8)
  );

  usb_rx_timer #(
    .CLKS_PER_BIT  (4),
    .SAMPLE_POINT  (1),
    .BITS_PER_BYTE (8)
  ) dut4 (
    .clk           (clk),
    .rst           (rst),
    .d_edge        (d_edge),
    .rcving        (rcving),
    .shift_enable  (se4),
    .byte_received (br4),
    .bit_count     (bc4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int t, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle(input logic d, input logic r);
    @(posedge clk);
    #1;
    d_edge = d;
    rcving = r;
    @(negedge clk);
  endtask

  task automatic go_idle();
    next_cycle(1'b0, 1'b0);
    next_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int exp_bc;

    rst    = 1'b1;
    d_edge = 1'b0;
    rcving = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_se", 0, 32'(se8), 32'd0);
    check("reset_br", 0, 32'(br8), 32'd0);
    check("reset_bc", 0, 32'(bc8), 32'd0);

    // Edge with rcving low is ignored.
    next_cycle(1'b1, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      next_cycle(1'b0, 1'b0);
      check("ignored_edge_se", t, 32'(se8), 32'd0);
    end

    // Basic byte: pulses at 3, 11, ..., 59; byte strobe at 60.
    for (int t = 0; t <= 64; t++) begin
      next_cycle(t == 0, 1'b1);
      exp_bc = (t <= 3) ? 0 : (((t - 4) / 8) + 1) % 8;
      check("basic_se", t, 32'(se8), 32'(t >= 3 && (t - 3) % 8 == 0));
      check("basic_bc", t, 32'(bc8), 32'(exp_bc));
      check("basic_br", t, 32'(br8), 32'(t == 60));
    end
    go_idle();
    check("basic_idle_bc", 0, 32'(bc8), 32'd0);

    // Resync at t9 moves the sample points to 12 and 20.
    for (int t = 0; t <= 21; t++) begin
      next_cycle(t == 0 || t == 9, 1'b1);
      check("resync_se", t, 32'(se8), 32'(t == 3 || t == 12 || t == 20));
    end
    go_idle();

    // Edge on the sample cycle keeps that pulse; next at 6, then 14.
    for (int t = 0; t <= 14; t++) begin
      next_cycle(t == 0 || t == 3, 1'b1);
      check("sample_edge_se", t, 32'(se8), 32'(t == 3 || t == 6 || t == 14));
    end
    go_idle();

    // Abort mid-byte at t30; edge at t35 with rcving low is ignored.
    for (int t = 0; t <= 45; t++) begin
      next_cycle(t == 0 || t == 35, t < 30);
      exp_bc = (t <= 3) ? 0 : (t >= 31) ? 0 : ((t - 4) / 8) + 1;
      check("abort_se", t, 32'(se8),
            32'(t == 3 || t == 11 || t == 19 || t == 27));
      check("abort_bc", t, 32'(bc8), 32'(exp_bc));
      check("abort_br", t, 32'(br8), 32'd0);
    end
    go_idle();

    // Fast instance: pulses every 4 cycles from t1, byte strobes at 30 and 62.
    for (int t = 0; t <= 63; t++) begin
      next_cycle(t == 0, 1'b1);
      exp_bc = (t <= 1) ? 0 : (((t - 2) / 4) + 1) % 8;
      check("fast_se", t, 32'(se4), 32'(t >= 1 && (t - 1) % 4 == 0));
      check("fast_bc", t, 32'(bc4), 32'(exp_bc));
      check("fast_br", t, 32'(br4), 32'(t == 30 || t == 62));
    end
    go_idle();

    // Asynchronous reset in the middle of a sample cycle.
    for (int t = 0; t <= 11; t++) begin
      next_cycle(t == 0, 1'b1);
    end
    check("pre_reset_se", 11, 32'(se8), 32'd1);
    check("pre_reset_bc", 11, 32'(bc8), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_se", 11, 32'(se8), 32'd0);
    check("async_reset_bc", 11, 32'(bc8), 32'd0);
    check("async_reset_br", 11, 32'(br8), 32'd0);
    check("async_reset_bc4", 11, 32'(bc4), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    d_edge = 1'b0;
    rcving = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      check("post_reset_se", t, 32'(se8), 32'd0);
      check("post_reset_br", t, 32'(br8), 32'd0);
      check("post_reset_se4", t, 32'(se4), 32'd0);
      check("post_reset_br4", t, 32'(br4), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=0 observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_rx_timer.md
Name: usb_rx_timer

Overview:
- Bit-timing stage directly downstream of the USB edge detector.
- Consumes the single-cycle `d_edge` transition pulse and realigns a per-bit phase counter on every edge.
- Produces a mid-bit `shift_enable` strobe for the RX shift register and a `byte_received` strobe after every 8 sampled bits.
- Sits between the edge detector and the RX shift register / RX control FSM.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per USB bit time; legal range >= 4.
- SAMPLE_POINT, 3, phase value at which the bit is sampled; legal range 1..CLKS_PER_BIT-1.
- BITS_PER_BYTE, 8, sampled bits per `byte_received` strobe; legal range >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_edge  input  1  one-cycle pulse on every D+ transition, from the edge detector.
- rcving  input  1  receive window from the RX control FSM; low forces idle.
- shift_enable  output  1  one-cycle strobe; the shift register samples the bit this cycle.
- byte_received  output  1  one-cycle strobe, the cycle after the last bit of a byte is sampled.
- bit_count  output  $clog2(BITS_PER_BYTE)  number of bits sampled so far in the current byte.

Behaviour:
- Reset: clock is single `clk`; reset is asynchronous, active-high, named `rst`. On reset, state=IDLE, phase=0, bit_count=0, shift_enable=0, byte_received=0.
- Widths: phase register is $clog2(CLKS_PER_BIT) bits. All counters are unsigned and wrap explicitly; they never rely on natural overflow.
- State IDLE:
  - phase and bit_count are held at 0.
  - If rcving=1 and d_edge=1, go to RUN with next phase=1. The edge cycle is treated as phase 0.
  - d_edge with rcving=0 is ignored.
- State RUN:
  - When d_edge=1, next phase=1 (resync). This applies at any phase, including SAMPLE_POINT.
  - Otherwise next phase = (phase==CLKS_PER_BIT-1) ? 0 : phase+1.
- RUN to IDLE: when rcving=0, go to IDLE on the next edge. phase and bit_count clear to 0 at the same time, and any partial byte is discarded with no `byte_received`. rcving=0 has priority over d_edge.
- shift_enable:
  - Decoded from registered state: asserted when state==RUN and phase==SAMPLE_POINT.
  - Exactly one pulse per bit period when no edge interferes.
  - A resync edge that lands on the sample cycle does not suppress that cycle's pulse.
- bit_count: increments on each shift_enable. If bit_count==BITS_PER_BYTE-1 when shift_enable fires, it wraps to 0 instead.
- byte_received: registered, asserted the cycle after the shift_enable that wraps bit_count. It is suppressed if rcving=0 in that same cycle.
- Latency: from a d_edge accepted in IDLE at cycle t0:
  - first shift_enable at t0+SAMPLE_POINT;
  - subsequent pulses every CLKS_PER_BIT cycles, absent further edges.
- Simultaneous events: d_edge in the same cycle as the phase wrap resolves as resync (next phase=1).
- Reset mid-byte: immediate return to the reset values. No strobe may be emitted in the cycle after reset deassertion.

Test Plan:
- Reset: assert rst mid-RUN at arbitrary phase -> all outputs 0 asynchronously; state IDLE; no strobes for 2 cycles after deassert while rcving=0.
- Basic byte: rcving=1, single d_edge at t0, no further edges, defaults -> shift_enable at t3, t11, ..., t59 (8 pulses); bit_count 1..7 then 0; byte_received high only at t60.
- Resync: edge at t0, second d_edge at t9 -> shift_enable at t3, t12, t20 (not t11, t19).
- Edge on sample cycle: edge at t0, d_edge at t3 -> shift_enable at t3 still asserted; next pulse t6+... = t6? No: phase=1 at t4, so next pulse at t6. Verify exact t6.
- Abort: rcving drops at t30 mid-byte -> IDLE at t31; bit_count=0; no byte_received; d_edge at t35 with rcving=0 ignored.
- Back-to-back bytes with parameter override CLKS_PER_BIT=4, SAMPLE_POINT=1: edge at t0 -> shift_enable every 4 cycles from t1; byte_received at t30 and t62 with rcving held high.
